ula_ctrl: RTL and testbench

ULA_CTRL -- requirements
Module: ula_ctrl

---
 rtl/ula_ctrl.sv | 115 +++++++++++
 tb/tb_ula_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_ctrl.sv
// ALU sequencer: accepts one request, holds operands for SETTLE_CYCLES, then captures the result.
// Optional macro ULA_CTRL_DIV0_DET_EN forces 16'hFFFF with rsp_err on divide-by-zero captures.
module ula_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_sel,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic [3:0]  ula_sel,
    output logic [7:0]  ula_a,
    output logic [7:0]  ula_b,
    input  logic [15:0] ula_s,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
`ifdef ULA_CTRL_DIV0_DET_EN
    localparam bit DIV0_EN = 1'b1;
`else
    localparam bit DIV0_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        live_q;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] data_q, data_d;
    logic        zero_q, zero_d, err_q, err_d;
    logic        accept, capture, div0;
    logic [15:0] result;

    // live_q keeps req_ready low while reset is held, rising on the first released edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DRIVE;
            DRIVE:   if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && live_q;
        rsp_valid = (state_q == RESP);
        accept    = req_ready && req_valid;
        capture   = (state_q == DRIVE) && (cnt_q == 4'd0);
        div0      = DIV0_EN && (sel_q == 4'b0011) && (b_q == 8'd0);
        result    = div0 ? 16'hFFFF : ula_s;

        cnt_d  = cnt_q;
        sel_d  = sel_q;
        a_d    = a_q;
        b_d    = b_q;
        data_d = data_q;
        zero_d = zero_q;
        err_d  = err_q;
        if (accept) begin
            sel_d = req_sel;
            a_d   = req_a;
            b_d   = req_b;
            cnt_d = CNT_INIT;
        end else if ((state_q == DRIVE) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (capture) begin
            data_d = result;
            zero_d = (result == 16'd0);
            err_d  = div0;
        end
    end

    assign ula_sel  = sel_q;
    assign ula_a    = a_q;
    assign ula_b    = b_q;
    assign rsp_data = data_q;
    assign rsp_zero = zero_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed bench for ula_ctrl: two instances (SETTLE_CYCLES=1 and 4), shared ALU model, scoreboard queues.
module tb_ula_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rsp_ready;
    logic [3:0]  req_sel;
    logic [7:0]  req_a, req_b;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_zero  [2];
    logic        rsp_err   [2];
    logic [3:0]  ula_sel   [2];
    logic [7:0]  ula_a     [2];
    logic [7:0]  ula_b     [2];
    logic [15:0] ula_s     [2];
    logic [15:0] rsp_data  [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (s)
            4'b0000: return wa + wb;
            4'b0001: return wa - wb;
            4'b0010: return wa * wb;
            4'b0011: return (b == 8'd0) ? 16'h0BAD : wa / wb;
            4'b1000: return wa & wb;
            4'b1001: return wa | wb;
            4'b1111: return {15'd0, a == b};
            default: return wa ^ wb;
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.data = alu(s, a, b);
        e.err  = 1'b0;
`ifdef ULA_CTRL_DIV0_DET_EN
        if (s == 4'b0011 && b == 8'd0) begin
            e.data = 16'hFFFF;
            e.err  = 1'b1;
        end
`endif
        e.zero = (e.data == 16'd0);
        return e;
    endfunction

    assign ula_s[0] = alu(ula_sel[0], ula_a[0], ula_b[0]);
    assign ula_s[1] = alu(ula_sel[1], ula_a[1], ula_b[1]);

    ula_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
        .ula_sel(ula_sel[0]), .ula_a(ula_a[0]), .ula_b(ula_b[0]), .ula_s(ula_s[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[0]), .rsp_zero(rsp_zero[0]), .rsp_err(rsp_err[0])
    );

    ula_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
        .ula_sel(ula_sel[1]), .ula_a(ula_a[1]), .ula_b(ula_b[1]), .ula_s(ula_s[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[1]), .rsp_zero(rsp_zero[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input int d, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                          input bit keep, input bit push, output int acc);
        int n = 0;
        req_sel = s;
        req_a = a;
        req_b = b;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", req_ready[d], 1);
        @(negedge clk);
        acc = cyc;
        if (push) begin
            if (d == 0) sb0.push_back(model(s, a, b));
            else        sb1.push_back(model(s, a, b));
        end
        if (!keep) req_valid[d] = 1'b0;
    endtask

    task automatic get_rsp(input int d, input string tag, output int seen);
        int   n = 0;
        int   pending;
        exp_t e;
        while (!rsp_valid[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        seen = cyc;
        chk({tag, "_valid"}, rsp_valid[d], 1);
        pending = (d == 0) ? sb0.size() : sb1.size();
        chk({tag, "_pending"}, pending, 1);
        if (pending > 0) begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk({tag, "_data"}, rsp_data[d], e.data);
            chk({tag, "_zero"}, rsp_zero[d], e.zero);
            chk({tag, "_err"},  rsp_err[d],  e.err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc, seen, a0, a1, a2, n;
        bit         saw_v;
        logic [3:0] ts [4];
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        ts = '{4'b0001, 4'b0010, 4'b1001, 4'b0110};
        ta = '{8'd5, 8'd255, 8'hA5, 8'h3C};
        tb = '{8'd9, 8'd255, 8'h5A, 8'h3C};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_sel = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", req_ready[d], 0);
            chk("rst_rsp_valid", rsp_valid[d], 0);
            chk("rst_rsp_data",  rsp_data[d],  0);
            chk("rst_rsp_zero",  rsp_zero[d],  0);
            chk("rst_rsp_err",   rsp_err[d],   0);
            chk("rst_ula_sel",   ula_sel[d],   0);
            chk("rst_ula_a",     ula_a[d],     0);
            chk("rst_ula_b",     ula_b[d],     0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst0", req_ready[0], 1);
        chk("ready_after_rst1", req_ready[1], 1);

        // basic add, latency 1
        accept(0, 4'b0000, 8'd200, 8'd100, 1'b0, 1'b1, acc);
        chk("add_ula_a", ula_a[0], 200);
        get_rsp(0, "add", seen);
        chk("add_latency", seen - acc, 1);
        chk("add_data_const", rsp_data[0], 16'd300);
        @(negedge clk);
        chk("add_back_idle", req_ready[0], 1);
        chk("add_rsp_gone", rsp_valid[0], 0);
        chk("add_hold_ula_a", ula_a[0], 200);
        chk("add_hold_data", rsp_data[0], 16'd300);

        // backpressure, with a request offered while busy
        rsp_ready = 1'b0;
        accept(0, 4'b1000, 8'hF0, 8'h0F, 1'b0, 1'b1, acc);
        get_rsp(0, "bp", seen);
        req_valid[0] = 1'b1;
        req_sel = 4'b0000;
        req_a = 8'd1;
        req_b = 8'd1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid[0], 1);
            chk("bp_data",  rsp_data[0],  0);
            chk("bp_zero",  rsp_zero[0],  1);
            chk("bp_ready", req_ready[0], 0);
            chk("bp_ula_a", ula_a[0], 8'hF0);
        end
        req_valid[0] = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", req_ready[0], 1);
        chk("bp_release_valid", rsp_valid[0], 0);

        // assorted ops, full 16-bit results
        for (int i = 0; i < 4; i++) begin
            accept(0, ts[i], ta[i], tb[i], 1'b0, 1'b1, acc);
            get_rsp(0, "table", seen);
            @(negedge clk);
        end

        // divide by zero
        accept(0, 4'b0011, 8'd9, 8'd0, 1'b0, 1'b1, acc);
        get_rsp(0, "div0", seen);
`ifdef ULA_CTRL_DIV0_DET_EN
        chk("div0_data_const", rsp_data[0], 16'hFFFF);
        chk("div0_err_const", rsp_err[0], 1);
`else
        chk("div0_data_const", rsp_data[0], 16'h0BAD);
        chk("div0_err_const", rsp_err[0], 0);
`endif
        @(negedge clk);

        // settle length 4, operands frozen during DRIVE
        accept(1, 4'b0010, 8'd15, 8'd17, 1'b0, 1'b1, acc);
        n = 0;
        while (!rsp_valid[1] && n < 20) begin
            chk("settle_ula_a", ula_a[1], 15);
            chk("settle_ula_b", ula_b[1], 17);
            @(negedge clk);
            n++;
        end
        get_rsp(1, "settle", seen);
        chk("settle_latency", seen - acc, 4);
        chk("settle_data_const", rsp_data[1], 16'd255);
        @(negedge clk);

        // reset during DRIVE discards the operation
        accept(1, 4'b0000, 8'd1, 8'd2, 1'b0, 1'b0, acc);
        chk("midrst_in_drive", rsp_valid[1], 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid",  rsp_valid[1], 0);
        chk("midrst_ready",  req_ready[1], 0);
        chk("midrst_ula_a",  ula_a[1],     0);
        chk("midrst_ula_b",  ula_b[1],     0);
        chk("midrst_data",   rsp_data[1],  0);
        rst_n = 1'b1;
        saw_v = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1]) saw_v = 1'b1;
        end
        chk("midrst_no_rsp", saw_v, 0);
        accept(1, 4'b1111, 8'd7, 8'd7, 1'b0, 1'b1, acc);
        get_rsp(1, "postrst4", seen);
        chk("postrst4_const", rsp_data[1], 16'd1);
        @(negedge clk);
        accept(0, 4'b1111, 8'd7, 8'd7, 1'b0, 1'b1, acc);
        get_rsp(0, "postrst1", seen);
        chk("postrst1_const", rsp_data[0], 16'd1);
        @(negedge clk);

        // back-to-back with req_valid held high
        accept(0, 4'b0000, 8'd1, 8'd2, 1'b1, 1'b1, a0);
        get_rsp(0, "b2b0", seen);
        accept(0, 4'b0001, 8'd50, 8'd20, 1'b1, 1'b1, a1);
        get_rsp(0, "b2b1", seen);
        accept(0, 4'b1000, 8'hCC, 8'hAA, 1'b0, 1'b1, a2);
        get_rsp(0, "b2b2", seen);
        chk("b2b_gap01", a1 - a0, 3);
        chk("b2b_gap12", a2 - a1, 3);
        @(negedge clk);
        chk("sb_drained", sb0.size() + sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
